// File: rtl/mem_stage_pkg.sv
// Shared CPU definitions: pipeline bus layouts, load types and exception codes.
// Bus widths are derived from the structs so producer and consumer cannot drift.
package mem_stage_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_MOD  = 5'h01;
    localparam logic [4:0] EXC_TLBL = 5'h02;
    localparam logic [4:0] EXC_TLBS = 5'h03;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    typedef struct packed {
        logic b;
        logic bu;
        logic h;
        logic hu;
        logic w;
        logic l;
        logic r;
    } ld_type_t;

    localparam ld_type_t LD_NONE = 7'b0000000;
    localparam ld_type_t LD_B    = 7'b1000000;
    localparam ld_type_t LD_BU   = 7'b0100000;
    localparam ld_type_t LD_H    = 7'b0010000;
    localparam ld_type_t LD_HU   = 7'b0001000;
    localparam ld_type_t LD_W    = 7'b0000100;
    localparam ld_type_t LD_L    = 7'b0000010;
    localparam ld_type_t LD_R    = 7'b0000001;

    typedef struct packed {
        logic        res_from_mem;
        logic        mem_req;
        logic        ex;
        logic        eret_flush;
        logic        mfc0_op;
        logic        mtc0_op;
        logic [4:0]  excode;
        logic [31:0] badvaddr;
        logic [7:0]  c0_addr;
        logic [3:0]  byte_oh;
        logic [31:0] rt_value;
        ld_type_t    ld;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        ex;
        logic        eret_flush;
        logic        mfc0_op;
        logic        mtc0_op;
        logic [4:0]  excode;
        logic [31:0] badvaddr;
        logic [7:0]  c0_addr;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ms_to_ws_t;

    typedef struct packed {
        logic        rf_we;
        logic        rf_wdata_valid;
        logic [4:0]  dest;
        logic [31:0] result;
    } ms_to_ds_t;

    localparam int ES_TO_MS_BUS_WD = $bits(es_to_ms_t);
    localparam int MS_TO_WS_BUS_WD = $bits(ms_to_ws_t);
    localparam int MS_TO_DS_BUS_WD = $bits(ms_to_ds_t);

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data extraction by byte offset and type; lwl/lwr register merge is
// built only when MEM_UNALIGNED_LR_EN is defined, otherwise they return rdata.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] rt,
    input  logic [1:0]  offset,
    input  ld_type_t    ld,
    output logic [31:0] result
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] lwl_res;
    logic [31:0] lwr_res;

    always_comb begin
        rd_byte = rdata[7:0];
        unique case (offset)
            2'd0: rd_byte = rdata[7:0];
            2'd1: rd_byte = rdata[15:8];
            2'd2: rd_byte = rdata[23:16];
            2'd3: rd_byte = rdata[31:24];
        endcase
        rd_half = offset[1] ? rdata[31:16] : rdata[15:0];
    end

`ifdef MEM_UNALIGNED_LR_EN
    always_comb begin
        lwl_res = rdata;
        lwr_res = rdata;
        unique case (offset)
            2'd0: begin
                lwl_res = {rdata[7:0], rt[23:0]};
                lwr_res = rdata;
            end
            2'd1: begin
                lwl_res = {rdata[15:0], rt[15:0]};
                lwr_res = {rt[31:24], rdata[31:8]};
            end
            2'd2: begin
                lwl_res = {rdata[23:0], rt[7:0]};
                lwr_res = {rt[31:16], rdata[31:16]};
            end
            2'd3: begin
                lwl_res = rdata;
                lwr_res = {rt[31:8], rdata[31:24]};
            end
        endcase
    end
`else
    logic unused_lr;
    assign unused_lr = ^{ld.l, ld.r, rt};
    assign lwl_res   = rdata;
    assign lwr_res   = rdata;
`endif

    always_comb begin
        result = rdata;
        unique case (1'b1)
            ld.b:    result = {{24{rd_byte[7]}}, rd_byte};
            ld.bu:   result = {24'd0, rd_byte};
            ld.h:    result = {{16{rd_half[15]}}, rd_half};
            ld.hu:   result = {16'd0, rd_half};
            ld.w:    result = rdata;
            ld.l:    result = lwl_res;
            ld.r:    result = lwr_res;
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: holds one instruction, waits for its data response and
// drops responses belonging to requests orphaned by a commit flush.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DISCARD_CNT_W = 2
)
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
    output logic                       ms_to_es_ex,
    output logic                       ms_to_es_mtc0,
    input  logic                       ms_flush,
    input  logic                       data_data_ok,
    input  logic [31:0]                data_rdata
);

    es_to_ms_t                ms_bus;
    logic                     ms_valid;
    logic                     data_got;
    logic [31:0]              data_buf;
    logic [DISCARD_CNT_W-1:0] discard_cnt;

    logic        cnt_zero;
    logic        cnt_max;
    logic        rsp_hit;
    logic        ms_ready_go;
    logic        capture;
    logic        cnt_inc;
    logic        cnt_dec;
    logic [31:0] load_rdata;
    logic [31:0] load_result;
    logic [31:0] final_result;
    ms_to_ws_t   ws_bus;
    ms_to_ds_t   ds_bus;
    logic        unused_oh;

    assign unused_oh = ^ms_bus.byte_oh;

    assign cnt_zero = (discard_cnt == '0);
    assign cnt_max  = (discard_cnt == {DISCARD_CNT_W{1'b1}});

    // A response counts only if no orphaned request is still in flight.
    assign rsp_hit = data_data_ok && cnt_zero && ms_valid
                   && ms_bus.mem_req && !data_got;

    assign ms_ready_go = ms_bus.ex || !ms_bus.mem_req
                       || data_got || rsp_hit;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign capture        = es_to_ms_valid && ms_allowin;

    assign cnt_inc = ms_flush && ms_valid && ms_bus.mem_req
                   && !data_got && !data_data_ok;
    assign cnt_dec = data_data_ok && !cnt_zero;

    assign load_rdata = data_got ? data_buf : data_rdata;

    mem_load_align u_align (
        .rdata  (load_rdata),
        .rt     (ms_bus.rt_value),
        .offset (ms_bus.alu_result[1:0]),
        .ld     (ms_bus.ld),
        .result (load_result)
    );

    assign final_result = ms_bus.res_from_mem ? load_result
                                              : ms_bus.alu_result;

    always_comb begin
        ws_bus            = '0;
        ws_bus.ex         = ms_bus.ex;
        ws_bus.eret_flush = ms_bus.eret_flush;
        ws_bus.mfc0_op    = ms_bus.mfc0_op;
        ws_bus.mtc0_op    = ms_bus.mtc0_op;
        ws_bus.excode     = ms_bus.excode;
        ws_bus.badvaddr   = ms_bus.badvaddr;
        ws_bus.c0_addr    = ms_bus.c0_addr;
        ws_bus.gr_we      = ms_bus.gr_we;
        ws_bus.dest       = ms_bus.dest;
        ws_bus.result     = final_result;
        ws_bus.pc         = ms_bus.pc;
    end

    always_comb begin
        ds_bus                = '0;
        ds_bus.rf_we          = ms_valid && ms_bus.gr_we;
        ds_bus.rf_wdata_valid = ms_to_ws_valid && !ms_bus.mfc0_op;
        ds_bus.dest           = ms_bus.dest;
        ds_bus.result         = final_result;
    end

    assign ms_to_ws_bus  = ws_bus;
    assign ms_to_ds_bus  = ds_bus;
    assign ms_to_es_ex   = ms_valid && (ms_bus.ex || ms_bus.eret_flush);
    assign ms_to_es_mtc0 = ms_valid && ms_bus.mtc0_op;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid    <= 1'b0;
            ms_bus      <= '0;
            data_got    <= 1'b0;
            data_buf    <= 32'd0;
            discard_cnt <= '0;
        end else begin
            if (ms_flush)
                ms_valid <= 1'b0;
            else if (ms_allowin)
                ms_valid <= es_to_ms_valid;

            if (capture)
                ms_bus <= es_to_ms_bus;

            if (capture)
                data_got <= 1'b0;
            else if (rsp_hit)
                data_got <= 1'b1;

            if (rsp_hit)
                data_buf <= data_rdata;

            if (cnt_inc && !cnt_dec && !cnt_max)
                discard_cnt <= discard_cnt + 1'b1;
            else if (cnt_dec && !cnt_inc)
                discard_cnt <= discard_cnt - 1'b1;
        end
    end

endmodule
